// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register busy scoreboard.
//   Two write ports (wr1 wins on an address collision), NUM_RD combinational read
//   ports, a reserve port that marks a register busy, and a registered popcount of
//   the busy bits. Register 0 reads as zero and is never busy.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a read whose address matches an enabled write this cycle sees that write
//   undefined -> reads return the stored contents; a written value is visible next cycle

// One read port: array lookup plus optional same-cycle write forwarding.
module regfile_mp_rd #(
  parameter int DATA_W     = 64,
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_B = 5
) (
  input  logic [REG_COUNT-1:0][DATA_W-1:0] mem,
  input  logic [REG_COUNT-1:0]             busy,
  input  logic [REG_ADDR_B-1:0]            addr,
`ifdef REGFILE_BYPASS_EN
  input  logic                             wr0_en,
  input  logic [REG_ADDR_B-1:0]            wr0_addr,
  input  logic [DATA_W-1:0]                wr0_data,
  input  logic                             wr1_en,
  input  logic [REG_ADDR_B-1:0]            wr1_addr,
  input  logic [DATA_W-1:0]                wr1_data,
  input  logic                             rsv_en,
  input  logic [REG_ADDR_B-1:0]            rsv_addr,
`endif
  output logic [DATA_W-1:0]                data,
  output logic                             rd_busy
);

  // Lookup; mem[0] and busy[0] are held at zero by the storage logic.
  always_comb begin
    data    = mem[addr];
    rd_busy = busy[addr];
`ifdef REGFILE_BYPASS_EN
    // Forward an in-flight write; wr1 takes precedence, r0 never forwarded.
    // A forwarded result is no longer pending unless reserved again this cycle.
    if (addr != '0) begin
      if (wr1_en && wr1_addr == addr) begin
        data    = wr1_data;
        rd_busy = rsv_en && (rsv_addr == addr);
      end else if (wr0_en && wr0_addr == addr) begin
        data    = wr0_data;
        rd_busy = rsv_en && (rsv_addr == addr);
      end
    end
`endif
  end

endmodule

module regfile_mp #(
  parameter int DATA_W     = 64,
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_B = 5,
  parameter int NUM_RD     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr0_en,
  input  logic [REG_ADDR_B-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]              wr0_data,
  input  logic                           wr1_en,
  input  logic [REG_ADDR_B-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]              wr1_data,
  input  logic                           rsv_en,
  input  logic [REG_ADDR_B-1:0]          rsv_addr,
  input  logic [NUM_RD*REG_ADDR_B-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]       rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  output logic [REG_ADDR_B:0]            busy_cnt
);

  logic [REG_COUNT-1:0][DATA_W-1:0] mem;
  logic [REG_COUNT-1:0]             busy, busy_nxt;
  logic [REG_ADDR_B:0]              cnt_nxt;

  // Register storage; wr1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem <= '0;
    end else begin
      if (wr0_en && wr0_addr != '0) mem[wr0_addr] <= wr0_data;
      if (wr1_en && wr1_addr != '0) mem[wr1_addr] <= wr1_data;
    end
  end

  // Next scoreboard: writes release, reserve sets afterwards so it wins; r0 pinned clear.
  always_comb begin
    busy_nxt = busy;
    if (wr0_en) busy_nxt[wr0_addr] = 1'b0;
    if (wr1_en) busy_nxt[wr1_addr] = 1'b0;
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Popcount of the next scoreboard so busy_cnt moves on the same edge as busy.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 1; i < REG_COUNT; i++)
      cnt_nxt = cnt_nxt + {{REG_ADDR_B{1'b0}}, busy_nxt[i]};
  end

  // Scoreboard and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_mp_rd #(
      .DATA_W    (DATA_W),
      .REG_COUNT (REG_COUNT),
      .REG_ADDR_B(REG_ADDR_B)
    ) u_rd (
      .mem     (mem),
      .busy    (busy),
      .addr    (rd_addr[k*REG_ADDR_B +: REG_ADDR_B]),
`ifdef REGFILE_BYPASS_EN
      .wr0_en  (wr0_en),
      .wr0_addr(wr0_addr),
      .wr0_data(wr0_data),
      .wr1_en  (wr1_en),
      .wr1_addr(wr1_addr),
      .wr1_data(wr1_data),
      .rsv_en  (rsv_en),
      .rsv_addr(rsv_addr),
`endif
      .data    (rd_data[k*DATA_W +: DATA_W]),
      .rd_busy (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp (DATA_W=64, 32 regs, 2 read ports).
// Inputs change 1ns after a rising edge; outputs are checked 2ns after it.
module tb_regfile_mp;

  localparam int DW = 64;
  localparam int AB = 5;
  localparam int NR = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr0_en = 1'b0, wr1_en = 1'b0, rsv_en = 1'b0;
  logic [AB-1:0]     wr0_addr = '0, wr1_addr = '0, rsv_addr = '0;
  logic [DW-1:0]     wr0_data = '0, wr1_data = '0;
  logic [NR*AB-1:0]  rd_addr = '0;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [AB:0]       busy_cnt;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  regfile_mp #(.DATA_W(DW), .REG_COUNT(32), .REG_ADDR_B(AB), .NUM_RD(NR)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr0_en  (wr0_en),
    .wr0_addr(wr0_addr),
    .wr0_data(wr0_data),
    .wr1_en  (wr1_en),
    .wr1_addr(wr1_addr),
    .wr1_data(wr1_data),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_busy (rd_busy),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tot_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Advance to 1ns after the next rising edge (input-drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp_byp;

    // Reset from a known high level so the async edge is seen.
    #1 rst = 1'b0;
    #1;
    chk("rst_cnt",   {58'd0, busy_cnt}, 64'd0);
    chk("rst_rd0",   rd_data[0 +: DW], 64'd0);
    chk("rst_busy",  {62'd0, rd_busy}, 64'd0);
    tick();
    rst = 1'b1;

    // Basic: wr0 r1, wr1 r2 same cycle; read both.
    wr0_en = 1'b1; wr0_addr = 5'd1; wr0_data = 64'hDEADBEEFCAFEBABE;
    wr1_en = 1'b1; wr1_addr = 5'd2; wr1_data = 64'h0123456789ABCDEF;
    rd_addr = {5'd2, 5'd1};
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 64'hDEADBEEFCAFEBABE;
`else
    exp_byp = 64'd0;
`endif
    chk("basic_pre_rd0", rd_data[0 +: DW], exp_byp);
    tick();
    idle();
    #1;
    chk("basic_rd0", rd_data[0 +: DW],  64'hDEADBEEFCAFEBABE);
    chk("basic_rd1", rd_data[DW +: DW], 64'h0123456789ABCDEF);
    chk("basic_busy", {62'd0, rd_busy}, 64'd0);

    // Collision: wr1 wins.
    tick();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 64'h11;
    wr1_en = 1'b1; wr1_addr = 5'd5; wr1_data = 64'h22;
    rd_addr = {5'd1, 5'd5};
    tick();
    idle();
    #1;
    chk("coll_rd0", rd_data[0 +: DW], 64'h22);
    chk("coll_cnt", {58'd0, busy_cnt}, 64'd0);

    // Zero register: write and reserve ignored.
    tick();
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 64'hFFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_addr = {5'd0, 5'd0};
    #1;
    chk("zero_pre_rd0", rd_data[0 +: DW], 64'd0);
    tick();
    idle();
    #1;
    chk("zero_rd0",  rd_data[0 +: DW], 64'd0);
    chk("zero_busy", {62'd0, rd_busy}, 64'd0);
    chk("zero_cnt",  {58'd0, busy_cnt}, 64'd0);

    // Scoreboard: reserve r3 then r4.
    tick();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_addr = 5'd4;
    tick();
    idle();
    rd_addr = {5'd4, 5'd3};
    #1;
    chk("sb_cnt2",  {58'd0, busy_cnt}, 64'd2);
    chk("sb_busy2", {62'd0, rd_busy}, 64'd3);
    // Write r3 releases it.
    tick();
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 64'h33;
    tick();
    idle();
    #1;
    chk("sb_cnt1",  {58'd0, busy_cnt}, 64'd1);
    chk("sb_busy1", {62'd0, rd_busy}, 64'd2);
    chk("sb_rd3",   rd_data[0 +: DW], 64'h33);
    // Reserve + write r4 same edge (r4 already busy): stays busy, data written.
    tick();
    rsv_en = 1'b1; rsv_addr = 5'd4;
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 64'h44;
    #1;
    chk("sb_pre_busy4", {63'd0, rd_busy[1]}, 64'd1);
    tick();
    idle();
    #1;
    chk("sb_rw_cnt",   {58'd0, busy_cnt}, 64'd1);
    chk("sb_rw_busy4", {63'd0, rd_busy[1]}, 64'd1);
    chk("sb_rw_rd4",   rd_data[DW +: DW], 64'h44);

    // Bypass / write to a non-busy register.
    tick();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 64'hA5;
    rd_addr = {5'd4, 5'd7};
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 64'hA5;
`else
    exp_byp = 64'd0;
`endif
    chk("byp_pre_rd7",   rd_data[0 +: DW], exp_byp);
    chk("byp_pre_busy7", {63'd0, rd_busy[0]}, 64'd0);
    tick();
    idle();
    #1;
    chk("byp_rd7", rd_data[0 +: DW], 64'hA5);
    chk("byp_cnt", {58'd0, busy_cnt}, 64'd1);

    // Mid-run reset clears everything immediately.
    tick();
    rd_addr = {5'd4, 5'd1};
    rst = 1'b0;
    #1;
    chk("mrst_rd0",  rd_data[0 +: DW],  64'd0);
    chk("mrst_rd1",  rd_data[DW +: DW], 64'd0);
    chk("mrst_busy", {62'd0, rd_busy}, 64'd0);
    chk("mrst_cnt",  {58'd0, busy_cnt}, 64'd0);

    // Release; the first edge after release acts normally.
    tick();
    rst = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 64'h99;
    rsv_en = 1'b1; rsv_addr = 5'd10;
    rd_addr = {5'd10, 5'd9};
    tick();
    idle();
    #1;
    chk("rel_rd9",    rd_data[0 +: DW], 64'h99);
    chk("rel_busy10", {63'd0, rd_busy[1]}, 64'd1);
    chk("rel_cnt",    {58'd0, busy_cnt}, 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
